// File: rtl/sd_emmc_cmd_responder_pkg.sv
// Shared constants for the SD/eMMC command responder: card states, command indices,
// frame lengths and R1 status bit positions.
package sd_emmc_cmd_responder_pkg;

  typedef enum logic [3:0] {
    CARD_IDLE  = 4'd0,
    CARD_READY = 4'd1,
    CARD_IDENT = 4'd2,
    CARD_STBY  = 4'd3,
    CARD_TRAN  = 4'd4
  } card_state_e;

  typedef enum logic [2:0] {
    RX_WAIT  = 3'd0,
    RX_SHIFT = 3'd1,
    DECODE   = 3'd2,
    NCR_WAIT = 3'd3,
    TX_SHIFT = 3'd4
  } fsm_state_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_e;

  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_SEND_OP_COND = 6'd1;
  localparam logic [5:0] CMD_ALL_SEND_CID = 6'd2;
  localparam logic [5:0] CMD_SET_RCA      = 6'd3;
  localparam logic [5:0] CMD_SELECT_CARD  = 6'd7;
  localparam logic [5:0] CMD_SEND_EXT_CSD = 6'd8;
  localparam logic [5:0] CMD_SEND_STATUS  = 6'd13;
  localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
  localparam logic [5:0] CMD_READ_MULTI   = 6'd18;
  localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;
  localparam logic [5:0] CMD_WRITE_MULTI  = 6'd25;

  localparam int FRAME_LEN = 48;
  localparam int R2_LEN    = 136;

  localparam int ST_COM_CRC_ERROR  = 23;
  localparam int ST_ILLEGAL_CMD    = 22;
  localparam int ST_STATE_LSB      = 9;
  localparam int ST_READY_FOR_DATA = 8;

  function automatic logic is_tran_cmd(input logic [5:0] idx);
    return idx inside {CMD_SEND_EXT_CSD, CMD_SEND_STATUS, CMD_READ_SINGLE,
                       CMD_READ_MULTI, CMD_WRITE_SINGLE, CMD_WRITE_MULTI};
  endfunction

  function automatic logic [31:0] r1_status(input card_state_e st, input logic crc_err,
                                            input logic illegal);
    logic [31:0] s;
    s = '0;
    s[ST_COM_CRC_ERROR] = crc_err;
    s[ST_ILLEGAL_CMD] = illegal;
    s[ST_STATE_LSB +: 4] = st;
    s[ST_READY_FOR_DATA] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/sd_emmc_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, zero seed), one bit per enabled clock, MSB first.
module sd_emmc_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    end
  end

endmodule

// File: rtl/sd_emmc_cmd_responder.sv
// SD/eMMC card-side command responder: receives 48-bit host commands, tracks card state
// and answers with R1/R2/R3. Define SD_EMMC_CMD_CRC_CHK_EN to reject frames with a bad CRC7.
module sd_emmc_cmd_responder
  import sd_emmc_cmd_responder_pkg::*;
#(
  parameter int           NCR = 2,
  parameter logic [31:0]  OCR = 32'hC0FF_8080,
  parameter logic [127:0] CID = 128'h0
) (
  input  logic        sd_clk,
  input  logic        rst_n,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic [3:0]  card_state_o,
  output logic [2:0]  dbg_state
);

  fsm_state_e  state, state_nxt;
  card_state_e card, card_nxt;
  resp_e       resp;
  logic [7:0]   cnt;
  logic [7:0]   tx_last;
  logic [45:0]  rx_sh;
  logic [135:0] tx_sh;
  logic         tx_r1;
  logic         rx_ok;
  logic         crc_err, illegal;
  logic         set_illegal, go_idle;
  logic         rx_done, ncr_done, tx_done, frame_ok, crc_ok;
  logic [6:0]   rx_crc, tx_crc;
  logic [2:0]   crc_pos;

  // rx_sh[k] holds frame bit k+1 once the end bit is on cmd_i
  assign rx_done  = (state == RX_SHIFT) && (cnt == 8'd46);
  assign ncr_done = (state == NCR_WAIT) && (cnt == 8'(NCR - 2));
  assign tx_done  = (state == TX_SHIFT) && (cnt == tx_last);
  assign frame_ok = rx_sh[45] && cmd_i && crc_ok;

`ifdef SD_EMMC_CMD_CRC_CHK_EN
  assign crc_ok = (rx_crc == rx_sh[6:0]);
`else
  logic unused_rx_crc;
  assign crc_ok = 1'b1;
  assign unused_rx_crc = ^{rx_crc, rx_sh[6:0]};
`endif

  // Start bit is 0 and the seed is 0, so feeding from the direction bit gives the same CRC
  sd_emmc_crc7 u_rx_crc (
    .clk  (sd_clk),
    .rst_n(rst_n),
    .clear(state == RX_WAIT),
    .en   ((state == RX_SHIFT) && (cnt < 8'd39)),
    .din  (cmd_i),
    .crc  (rx_crc)
  );

  sd_emmc_crc7 u_tx_crc (
    .clk  (sd_clk),
    .rst_n(rst_n),
    .clear(state != TX_SHIFT),
    .en   ((state == TX_SHIFT) && (cnt < 8'd40)),
    .din  (tx_sh[135]),
    .crc  (tx_crc)
  );

  always_comb begin
    resp        = RESP_NONE;
    card_nxt    = card;
    set_illegal = 1'b0;
    go_idle     = 1'b0;
    if (cmd_index_o == CMD_GO_IDLE) begin
      card_nxt = CARD_IDLE;
      go_idle  = 1'b1;
    end else if (cmd_index_o == CMD_SEND_OP_COND && card == CARD_IDLE) begin
      resp     = RESP_R3;
      card_nxt = CARD_READY;
    end else if (cmd_index_o == CMD_ALL_SEND_CID && card == CARD_READY) begin
      resp     = RESP_R2;
      card_nxt = CARD_IDENT;
    end else if (cmd_index_o == CMD_SET_RCA && card == CARD_IDENT) begin
      resp     = RESP_R1;
      card_nxt = CARD_STBY;
    end else if (cmd_index_o == CMD_SELECT_CARD && card == CARD_STBY) begin
      resp     = RESP_R1;
      card_nxt = CARD_TRAN;
    end else if (card == CARD_TRAN && is_tran_cmd(cmd_index_o)) begin
      resp     = RESP_R1;
    end else begin
      set_illegal = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RX_WAIT:  if (!cmd_i) state_nxt = RX_SHIFT;
      RX_SHIFT: if (rx_done) state_nxt = DECODE;
      DECODE:   state_nxt = (rx_ok && resp != RESP_NONE) ? NCR_WAIT : RX_WAIT;
      NCR_WAIT: if (ncr_done) state_nxt = TX_SHIFT;
      TX_SHIFT: if (tx_done) state_nxt = RX_WAIT;
      default:  state_nxt = RX_WAIT;
    endcase
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) state <= RX_WAIT;
    else        state <= state_nxt;
  end

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      tx_last     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '1;
      tx_r1       <= 1'b0;
      rx_ok       <= 1'b0;
      crc_err     <= 1'b0;
      illegal     <= 1'b0;
      card        <= CARD_IDLE;
      cmd_index_o <= '0;
      cmd_arg_o   <= '0;
    end else begin
      unique case (state)
        RX_WAIT: cnt <= '0;
        RX_SHIFT: begin
          cnt   <= cnt + 8'd1;
          rx_sh <= {rx_sh[44:0], cmd_i};
          if (rx_done) begin
            rx_ok <= frame_ok;
            if (frame_ok) begin
              cmd_index_o <= rx_sh[44:39];
              cmd_arg_o   <= rx_sh[38:7];
            end
            if (rx_sh[45] && cmd_i && !crc_ok) crc_err <= 1'b1;
          end
        end
        DECODE: begin
          cnt <= '0;
          if (rx_ok) begin
            card    <= card_nxt;
            tx_r1   <= (resp == RESP_R1);
            tx_last <= (resp == RESP_R2) ? 8'(R2_LEN - 1) : 8'(FRAME_LEN - 1);
            if (go_idle) begin
              crc_err <= 1'b0;
              illegal <= 1'b0;
            end
            if (set_illegal) illegal <= 1'b1;
            unique case (resp)
              RESP_R1: tx_sh <= {2'b00, cmd_index_o, r1_status(card, crc_err, illegal),
                                 7'h00, 1'b1, 88'h0};
              RESP_R2: tx_sh <= {2'b00, 6'h3F, CID[127:1], 1'b1};
              RESP_R3: tx_sh <= {2'b00, 6'h3F, OCR, 7'h7F, 1'b1, 88'h0};
              default: tx_sh <= '1;
            endcase
          end
        end
        NCR_WAIT: cnt <= ncr_done ? 8'd0 : cnt + 8'd1;
        TX_SHIFT: begin
          cnt   <= cnt + 8'd1;
          tx_sh <= {tx_sh[134:0], 1'b1};
          if (tx_done && tx_r1) begin
            crc_err <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // R1 CRC occupies bits 40..46; 40 is a multiple of 8 so cnt[2:0] counts 0..6 there
  assign crc_pos = 3'd6 - cnt[2:0];

  always_comb begin
    cmd_o = 1'b1;
    if (state == TX_SHIFT) begin
      if (tx_r1 && cnt >= 8'd40 && cnt <= 8'd46) cmd_o = tx_crc[crc_pos];
      else                                       cmd_o = tx_sh[135];
    end
  end

  assign cmd_oe       = (state == TX_SHIFT);
  assign cmd_valid_o  = (state == DECODE) && rx_ok;
  assign card_state_o = card;
  assign dbg_state    = state;

endmodule

// File: tb/tb_sd_emmc_cmd_responder.sv
// Directed bench for sd_emmc_cmd_responder: host frame driver, response capture and
// hand-built expected responses.
module tb_sd_emmc_cmd_responder;

  localparam int           NCR_T = 2;
  localparam logic [31:0]  OCR_T = 32'hC0FF_8080;
  localparam logic [127:0] CID_T = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211;

  logic        sd_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        cmd_i  = 1'b1;
  logic        cmd_o, cmd_oe, cmd_valid_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [3:0]  card_state_o;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  int           v_cnt;
  logic [5:0]   v_idx;
  logic [31:0]  v_arg;
  bit           got;
  int           lat;
  logic [135:0] resp;
  bit           oe_hold;
  logic         end_oe;

  sd_emmc_cmd_responder #(.NCR(NCR_T), .OCR(OCR_T), .CID(CID_T)) dut (
    .sd_clk      (sd_clk),
    .rst_n       (rst_n),
    .cmd_i       (cmd_i),
    .cmd_o       (cmd_o),
    .cmd_oe      (cmd_oe),
    .cmd_valid_o (cmd_valid_o),
    .cmd_index_o (cmd_index_o),
    .cmd_arg_o   (cmd_arg_o),
    .card_state_o(card_state_o),
    .dbg_state   (dbg_state)
  );

  always #5 sd_clk = ~sd_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] r1(input logic [5:0] idx, input logic [31:0] st);
    logic [39:0] h;
    h = {2'b00, idx, st};
    return {88'h0, h, crc7(h), 1'b1};
  endfunction

  function automatic logic [135:0] r3();
    return {88'h0, 2'b00, 6'h3F, OCR_T, 7'h7F, 1'b1};
  endfunction

  function automatic logic [135:0] r2();
    return {2'b00, 6'h3F, CID_T[127:1], 1'b1};
  endfunction

  // Returns #1 after the edge that samples the end bit
  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input bit dir,
                            input bit endb, input bit bad_crc);
    logic [39:0] h;
    logic [47:0] f;
    h = {1'b0, dir, idx, arg};
    f = {h, crc7(h) ^ (bad_crc ? 7'h01 : 7'h00), endb};
    for (int i = 47; i >= 0; i--) begin
      @(posedge sd_clk);
      #1 cmd_i = f[i];
    end
    @(posedge sd_clk);
    #1 cmd_i = 1'b1;
  endtask

  task automatic observe(input int len);
    v_cnt = 0; v_idx = '0; v_arg = '0; got = 0; lat = 0; resp = '0; oe_hold = 1; end_oe = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge sd_clk);
      if (cmd_valid_o) begin
        v_cnt++;
        v_idx = cmd_index_o;
        v_arg = cmd_arg_o;
      end
      if (cmd_oe) got = 1;
      else        lat++;
    end
    if (got) begin
      resp = {resp[134:0], cmd_o};
      for (int j = 1; j < len; j++) begin
        @(negedge sd_clk);
        if (!cmd_oe) oe_hold = 0;
        resp = {resp[134:0], cmd_o};
      end
      @(negedge sd_clk);
      end_oe = cmd_oe;
    end
  endtask

  task automatic do_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input bit dir, input bit endb, input bit bad_crc, input bit exp_valid,
                        input int rlen, input logic [135:0] exp_r, input logic [3:0] exp_st);
    send_frame(idx, arg, dir, endb, bad_crc);
    observe((rlen == 0) ? 48 : rlen);
    check({tag, ".valid_pulses"}, 136'(v_cnt), 136'(exp_valid));
    if (exp_valid) begin
      check({tag, ".index"}, 136'(v_idx), 136'(idx));
      check({tag, ".arg"}, 136'(v_arg), 136'(arg));
    end
    check({tag, ".responded"}, 136'(got), 136'(rlen != 0));
    if (rlen != 0) begin
      check({tag, ".ncr_latency"}, 136'(lat), 136'(NCR_T));
      check({tag, ".resp"}, resp, exp_r);
      check({tag, ".oe_held"}, 136'(oe_hold), 136'(1));
      check({tag, ".oe_after_end"}, 136'(end_oe), 136'(0));
    end
    check({tag, ".card_state"}, 136'(card_state_o), 136'(exp_st));
    repeat (3) @(posedge sd_clk);
  endtask

  int  oe_cnt;
  bit  seen;

  initial begin
    // reset values while rst_n is low
    #12;
    check("rst.cmd_oe", 136'(cmd_oe), 136'(0));
    check("rst.cmd_o", 136'(cmd_o), 136'(1));
    check("rst.valid", 136'(cmd_valid_o), 136'(0));
    check("rst.index", 136'(cmd_index_o), 136'(0));
    check("rst.arg", 136'(cmd_arg_o), 136'(0));
    check("rst.card_state", 136'(card_state_o), 136'(0));
    check("rst.fsm", 136'(dbg_state), 136'(0));
    @(negedge sd_clk);
    rst_n = 1'b1;
    repeat (3) @(posedge sd_clk);

    do_cmd("cmd0", 6'd0, 32'h0, 1, 1, 0, 1, 0, '0, 4'd0);
    do_cmd("cmd1", 6'd1, 32'h40FF_8000, 1, 1, 0, 1, 48, r3(), 4'd1);
    do_cmd("cmd2", 6'd2, 32'h0, 1, 1, 0, 1, 136, r2(), 4'd2);
    do_cmd("cmd3", 6'd3, 32'h0, 1, 1, 0, 1, 48, r1(6'd3, 32'h0000_0500), 4'd3);
    do_cmd("cmd7", 6'd7, 32'h0001_0000, 1, 1, 0, 1, 48, r1(6'd7, 32'h0000_0700), 4'd4);
    do_cmd("cmd17", 6'd17, 32'h0000_1234, 1, 1, 0, 1, 48, r1(6'd17, 32'h0000_0900), 4'd4);
    do_cmd("cmd2_tran", 6'd2, 32'h0, 1, 1, 0, 1, 0, '0, 4'd4);
    do_cmd("cmd13_ill", 6'd13, 32'h0001_0000, 1, 1, 0, 1, 48, r1(6'd13, 32'h0040_0900), 4'd4);
    do_cmd("cmd13_clr", 6'd13, 32'h0001_0000, 1, 1, 0, 1, 48, r1(6'd13, 32'h0000_0900), 4'd4);

    // malformed frames: no pulse, no state or status change
    do_cmd("dir0", 6'd13, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, '0, 4'd4);
    check("dir0.arg_kept", 136'(cmd_arg_o), 136'(32'h0001_0000));
    do_cmd("end0_cmd0", 6'd0, 32'h0, 1, 0, 0, 0, 0, '0, 4'd4);
    check("end0.index_kept", 136'(cmd_index_o), 136'(6'd13));
    do_cmd("cmd13_after_bad", 6'd13, 32'h0001_0000, 1, 1, 0, 1, 48,
           r1(6'd13, 32'h0000_0900), 4'd4);

`ifdef SD_EMMC_CMD_CRC_CHK_EN
    do_cmd("crc_bad", 6'd13, 32'h0001_0000, 1, 1, 1, 0, 0, '0, 4'd4);
    do_cmd("cmd13_crcerr", 6'd13, 32'h0001_0000, 1, 1, 0, 1, 48,
           r1(6'd13, 32'h0080_0900), 4'd4);
    do_cmd("cmd13_crcclr", 6'd13, 32'h0001_0000, 1, 1, 0, 1, 48,
           r1(6'd13, 32'h0000_0900), 4'd4);
`else
    do_cmd("crc_ignored", 6'd13, 32'h0001_0000, 1, 1, 1, 1, 48,
           r1(6'd13, 32'h0000_0900), 4'd4);
`endif

    // illegal flag cleared by CMD0, then rebuild to IDENT
    do_cmd("cmd1_tran", 6'd1, 32'h0, 1, 1, 0, 1, 0, '0, 4'd4);
    do_cmd("cmd0_b", 6'd0, 32'h0000_00AA, 1, 1, 0, 1, 0, '0, 4'd0);
    do_cmd("cmd1_b", 6'd1, 32'h0, 1, 1, 0, 1, 48, r3(), 4'd1);
    do_cmd("cmd2_b", 6'd2, 32'h0, 1, 1, 0, 1, 136, r2(), 4'd2);
    do_cmd("cmd3_b", 6'd3, 32'h0, 1, 1, 0, 1, 48, r1(6'd3, 32'h0000_0500), 4'd3);
    do_cmd("cmd13_stby", 6'd13, 32'h0, 1, 1, 0, 1, 0, '0, 4'd3);
    do_cmd("cmd0_c", 6'd0, 32'h0, 1, 1, 0, 1, 0, '0, 4'd0);
    do_cmd("cmd1_c", 6'd1, 32'h0, 1, 1, 0, 1, 48, r3(), 4'd1);

    // reset in the middle of an R2
    send_frame(6'd2, 32'h0, 1, 1, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sd_clk);
      if (cmd_oe) seen = 1;
    end
    check("mid_rst.r2_started", 136'(seen), 136'(1));
    repeat (60) @(negedge sd_clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst.cmd_oe", 136'(cmd_oe), 136'(0));
    check("mid_rst.cmd_o", 136'(cmd_o), 136'(1));
    check("mid_rst.card_state", 136'(card_state_o), 136'(0));
    check("mid_rst.fsm", 136'(dbg_state), 136'(0));
    repeat (3) @(negedge sd_clk);
    rst_n = 1'b1;
    oe_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge sd_clk);
      if (cmd_oe) oe_cnt++;
    end
    check("mid_rst.no_partial", 136'(oe_cnt), 136'(0));
    do_cmd("cmd1_after_rst", 6'd1, 32'h0, 1, 1, 0, 1, 48, r3(), 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
